// File: rtl/y86_prefetch_fetch.sv
// Y86-64 fetch stage backed by a byte prefetch queue: fills from instruction memory,
// decodes the instruction at the queue head, and restarts fetch on M/W-stage redirects.
module y86_prefetch_fetch #(
  parameter int          FETCH_BYTES = 8,
  parameter int          QDEPTH      = 32,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [63:0]              imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [8*FETCH_BYTES-1:0] imem_rsp_data,
  input  logic                     imem_rsp_error,
  input  logic [3:0]               M_icode,
  input  logic                     M_Cnd,
  input  logic [63:0]              M_valA,
  input  logic [3:0]               W_icode,
  input  logic [63:0]              W_valM,
  output logic                     f_valid,
  input  logic                     d_ready,
  output logic [2:0]               f_stat,
  output logic [3:0]               f_icode,
  output logic [3:0]               f_ifun,
  output logic [3:0]               f_rA,
  output logic [3:0]               f_rB,
  output logic [63:0]              f_valC,
  output logic [63:0]              f_valP,
  output logic [63:0]              f_predPC,
  output logic [63:0]              f_pc
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd2;
  localparam logic [2:0] STAT_INS = 3'd3;
  localparam logic [2:0] STAT_HLT = 3'd4;

  typedef enum logic {RUN, HALTED} state_t;

  state_t          state, state_next;
  logic [7:0]      q_mem [QDEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [63:0]     head_pc, fetch_addr, req_addr;
  logic            err_flag, outstanding, req_valid_q, drop_rsp;

  logic [7:0]      b [10];
  logic [3:0]      icode, ifun, len;
  logic            need_regids, need_valc, is_ins, have_insn, adr_case, halting;
  logic [63:0]     valc, redirect_pc;
  logic            redirect, xfer, push, rsp_fire, accept, issue;
  logic [CW-1:0]   free_bytes;

  // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 10; i++) b[i] = q_mem[head + PW'(i)];
    icode       = b[0][7:4];
    ifun        = b[0][3:0];
    is_ins      = (icode > 4'd11);
    need_regids = icode inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11};
    need_valc   = icode inside {4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
    len         = 4'd1 + {3'd0, need_regids} + (need_valc ? 4'd8 : 4'd0);
    valc        = '0;
    if (need_valc)
      valc = need_regids ? {b[9], b[8], b[7], b[6], b[5], b[4], b[3], b[2]}
                         : {b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1]};
  end

  // M-stage mispredict outranks a W-stage return
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = W_valM;
    if (M_icode == 4'd7 && !M_Cnd) begin
      redirect    = 1'b1;
      redirect_pc = M_valA;
    end else if (W_icode == 4'd9) begin
      redirect    = 1'b1;
    end
  end

  assign have_insn  = (count != '0) && (count >= CW'(len));
  assign adr_case   = err_flag && !have_insn;
  assign f_valid    = (state == RUN) && !redirect && (have_insn || err_flag);
  assign xfer       = f_valid && d_ready;
  assign halting    = adr_case || icode == 4'd0 || is_ins;
  assign rsp_fire   = outstanding && imem_rsp_valid;
  assign push       = rsp_fire && !drop_rsp && !imem_rsp_error && !redirect;
  assign accept     = req_valid_q && imem_req_ready;
  assign free_bytes = CW'(QDEPTH) - count;
  assign issue      = !req_valid_q && !outstanding && state == RUN && !err_flag && !redirect &&
                      (free_bytes >= CW'(FETCH_BYTES));

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr;

  always_comb begin
    f_stat   = STAT_AOK;
    f_icode  = 4'd0;
    f_ifun   = 4'd0;
    f_rA     = 4'hF;
    f_rB     = 4'hF;
    f_valC   = '0;
    f_valP   = '0;
    f_predPC = '0;
    f_pc     = '0;
    if (f_valid && adr_case) begin
      f_stat   = STAT_ADR;
      f_icode  = 4'd1;
      f_valP   = head_pc;
      f_predPC = head_pc;
      f_pc     = head_pc;
    end else if (f_valid) begin
      f_stat   = (icode == 4'd0) ? STAT_HLT : (is_ins ? STAT_INS : STAT_AOK);
      f_icode  = icode;
      f_ifun   = ifun;
      f_rA     = need_regids ? b[1][7:4] : 4'hF;
      f_rB     = need_regids ? b[1][3:0] : 4'hF;
      f_valC   = valc;
      f_valP   = head_pc + 64'(len);
      f_predPC = (icode == 4'd7 || icode == 4'd8) ? valc : head_pc + 64'(len);
      f_pc     = head_pc;
    end
  end

  always_comb begin
    state_next = state;
    if (redirect)              state_next = RUN;
    else if (xfer && halting)  state_next = HALTED;
  end

  // NOTE: the byte array carries no reset; occupancy alone says which bytes are meaningful.
  always_ff @(posedge clk) begin
    if (push)
      for (int i = 0; i < FETCH_BYTES; i++) q_mem[tail + PW'(i)] <= imem_rsp_data[8*i +: 8];
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      head_pc     <= RESET_PC;
      fetch_addr  <= RESET_PC;
      req_addr    <= RESET_PC;
      err_flag    <= 1'b0;
      outstanding <= 1'b0;
      req_valid_q <= 1'b0;
      drop_rsp    <= 1'b0;
    end else begin
      state <= state_next;
      if (rsp_fire) begin
        outstanding <= 1'b0;
        drop_rsp    <= 1'b0;
      end
      if (accept) begin
        req_valid_q <= 1'b0;
        outstanding <= 1'b1;
      end
      if (issue) begin
        req_valid_q <= 1'b1;
        req_addr    <= fetch_addr;
      end
      if (redirect) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        head_pc    <= redirect_pc;
        fetch_addr <= redirect_pc;
        err_flag   <= 1'b0;
        // whatever is still in flight belongs to the old path
        drop_rsp   <= req_valid_q || (outstanding && !imem_rsp_valid);
      end else begin
        if (push) tail <= tail + PW'(FETCH_BYTES);
        if (xfer && !adr_case) begin
          head    <= head + PW'(len);
          head_pc <= head_pc + 64'(len);
        end
        count <= count + (push ? CW'(FETCH_BYTES) : '0) - ((xfer && !adr_case) ? CW'(len) : '0);
        if (accept && !drop_rsp) fetch_addr <= fetch_addr + 64'(FETCH_BYTES);
        if (rsp_fire && !drop_rsp && imem_rsp_error) err_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_y86_prefetch_fetch.sv
// Scoreboard bench for y86_prefetch_fetch: directed memory images, expected
// instruction handoffs queued up front and compared by an independent monitor.
module tb_y86_prefetch_fetch;

  localparam int FB = 8;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] pred;
    logic [63:0] pc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imem_req_valid, imem_req_ready;
  logic [63:0]     imem_req_addr;
  logic            imem_rsp_valid;
  logic [8*FB-1:0] imem_rsp_data;
  logic            imem_rsp_error;
  logic [3:0]      M_icode, W_icode;
  logic            M_Cnd;
  logic [63:0]     M_valA, W_valM;
  logic            f_valid, d_ready;
  logic [2:0]      f_stat;
  logic [3:0]      f_icode, f_ifun, f_rA, f_rB;
  logic [63:0]     f_valC, f_valP, f_predPC, f_pc;

  int checks = 0;
  int errors = 0;
  int acc_count = 0;
  int lat = 0;
  logic [63:0] err_lo = 64'h0, err_hi = 64'h0;
  logic [7:0]  img [logic [63:0]];
  exp_t        exp_q [$];

  always #5 clk = ~clk;

  y86_prefetch_fetch #(.FETCH_BYTES(FB), .QDEPTH(32), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_error(imem_rsp_error),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA), .W_icode(W_icode), .W_valM(W_valM),
    .f_valid(f_valid), .d_ready(d_ready), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
    .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP), .f_predPC(f_predPC), .f_pc(f_pc)
  );

  function automatic logic [7:0] get_byte(input logic [63:0] a);
    return img.exists(a) ? img[a] : 8'h00;
  endfunction

  function automatic exp_t mk(input logic [2:0] s, input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                              input logic [63:0] vp, input logic [63:0] pp, input logic [63:0] pc);
    exp_t e;
    e.stat = s; e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
    e.valc = vc; e.valp = vp; e.pred = pp; e.pc = pc;
    return e;
  endfunction

  function automatic exp_t nop_at(input logic [63:0] pc);
    return mk(3'd1, 4'd1, 4'd0, 4'hF, 4'hF, 64'd0, pc + 64'd1, pc + 64'd1, pc);
  endfunction

  function automatic exp_t hlt_at(input logic [63:0] pc);
    return mk(3'd4, 4'd0, 4'd0, 4'hF, 4'hF, 64'd0, pc + 64'd1, pc + 64'd1, pc);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Memory model: one response per accepted request, lat cycles after acceptance.
  task automatic drive_rsp(input logic [63:0] a);
    for (int i = 0; i < FB; i++) imem_rsp_data[8*i +: 8] = get_byte(a + 64'(i));
    imem_rsp_error = (a >= err_lo) && (a < err_hi);
    imem_rsp_valid = 1'b1;
  endtask

  initial begin
    logic        hs;
    logic [63:0] hs_addr, rsp_addr;
    int          cd;
    cd = 0;
    rsp_addr = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_error = 1'b0;
    forever begin
      @(negedge clk);
      hs      = imem_req_valid && imem_req_ready && rst_n;
      hs_addr = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (!rst_n) cd = 0;
      else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) drive_rsp(rsp_addr);
        end
        if (hs) begin
          acc_count++;
          rsp_addr = hs_addr;
          if (lat == 0) drive_rsp(hs_addr);
          else cd = lat;
        end
      end
    end
  end

  // Monitor: every handoff to decode is compared with the next expected instruction.
  initial begin
    exp_t got, e;
    forever begin
      @(negedge clk);
      if (rst_n && f_valid && d_ready) begin
        got = mk(f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_predPC, f_pc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected: got stat=%0d icode=%h pc=%h, expected no transfer",
                   got.stat, got.icode, got.pc);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL xfer_pc%h: got stat=%0d ic=%h fn=%h rA=%h rB=%h valC=%h valP=%h pred=%h pc=%h expected stat=%0d ic=%h fn=%h rA=%h rB=%h valC=%h valP=%h pred=%h pc=%h",
                     e.pc, got.stat, got.icode, got.ifun, got.ra, got.rb, got.valc, got.valp, got.pred, got.pc,
                     e.stat, e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp, e.pred, e.pc);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    step(1);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_empty(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (!f_valid && n < budget) begin
      step(1);
      n++;
    end
    check(name, 64'(f_valid), 64'd1);
  endtask

  task automatic pulse_ready();
    d_ready = 1'b1;
    step(1);
    d_ready = 1'b0;
  endtask

  task automatic redirect_pulse(input logic [3:0] mi, input logic mc, input logic [63:0] mv,
                                input logic [3:0] wi, input logic [63:0] wv);
    step(1);
    M_icode = mi; M_Cnd = mc; M_valA = mv; W_icode = wi; W_valM = wv;
    step(1);
    M_icode = 4'd0; M_Cnd = 1'b1; W_icode = 4'd0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0;
    rst_n = 1'b0; d_ready = 1'b0; imem_req_ready = 1'b1;
    M_icode = 4'd0; M_Cnd = 1'b1; M_valA = '0; W_icode = 4'd0; W_valM = '0;
    step(2);

    // reset state
    check("rst_f_valid", 64'(f_valid), 64'd0);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_f_stat", 64'(f_stat), 64'd1);
    check("rst_f_icode", 64'(f_icode), 64'd0);
    check("rst_f_rA", 64'(f_rA), 64'hF);
    check("rst_f_rB", 64'(f_rB), 64'hF);
    check("rst_f_valC", f_valC, 64'd0);
    check("rst_f_pc", f_pc, 64'd0);

    // irmovq $10,%rsp then halt; no requests once halted
    img.delete();
    img[0] = 8'h30; img[1] = 8'hF4; img[2] = 8'h0A;
    exp_q.push_back(mk(3'd1, 4'd3, 4'd0, 4'hF, 4'd4, 64'd10, 64'd10, 64'd10, 64'd0));
    exp_q.push_back(hlt_at(64'd10));
    d_ready = 1'b1;
    do_reset();
    wait_empty(300, "irmovq_done");
    step(3);
    a0 = acc_count;
    step(20);
    check("halt_no_req", 64'(acc_count - a0), 64'd0);
    check("halt_no_valid", 64'(f_valid), 64'd0);

    // jXX prediction, then M-stage mispredict back to 0x09 flushes the queue
    img.delete();
    img[0] = 8'h70; img[1] = 8'h40; img[9] = 8'h10; img[10] = 8'h00;
    exp_q.push_back(mk(3'd1, 4'd7, 4'd0, 4'hF, 4'hF, 64'h40, 64'd9, 64'h40, 64'd0));
    exp_q.push_back(nop_at(64'd9));
    exp_q.push_back(nop_at(64'd9));
    exp_q.push_back(hlt_at(64'd10));
    d_ready = 1'b0;
    do_reset();
    wait_valid(100, "jxx_valid");
    pulse_ready();
    wait_valid(100, "nop9_valid");
    pulse_ready();
    redirect_pulse(4'd7, 1'b0, 64'h09, 4'd0, 64'd0);
    d_ready = 1'b1;
    wait_empty(300, "mispredict_done");

    // M and W redirect together: M wins; M_Cnd=1 leaves W in charge
    img.delete();
    img[0] = 8'h10; img[8'h20] = 8'h10; img[8'h21] = 8'h00; img[8'h80] = 8'h00;
    exp_q.push_back(nop_at(64'h20));
    exp_q.push_back(hlt_at(64'h21));
    d_ready = 1'b0;
    do_reset();
    wait_valid(100, "prio_valid");
    redirect_pulse(4'd7, 1'b0, 64'h20, 4'd9, 64'h80);
    d_ready = 1'b1;
    wait_empty(300, "prio_m_done");
    exp_q.push_back(hlt_at(64'h80));
    redirect_pulse(4'd7, 1'b1, 64'h20, 4'd9, 64'h80);
    wait_empty(300, "ret_w_done");

    // decode stall: queue fills to 32 bytes in four requests, outputs hold, nothing lost
    img.delete();
    for (int i = 0; i < 40; i++) img[64'(i)] = 8'h10;
    for (int i = 0; i < 40; i++) exp_q.push_back(nop_at(64'(i)));
    exp_q.push_back(hlt_at(64'd40));
    d_ready = 1'b0;
    do_reset();
    a0 = acc_count;
    for (int n = 0; n < 100 && (acc_count - a0) < 4; n++) step(1);
    check("fill_reqs", 64'(acc_count - a0), 64'd4);
    for (int c = 0; c < 5; c++) begin
      step(1);
      check("stall_valid", 64'(f_valid), 64'd1);
      check("stall_pc", f_pc, 64'd0);
      check("stall_icode", 64'(f_icode), 64'd1);
    end
    check("fill_stop", 64'(acc_count - a0), 64'd4);
    d_ready = 1'b1;
    wait_empty(600, "stream_done");

    // redirect with a request in flight: its response must be dropped
    img.delete();
    img[64'h100] = 8'h10; img[64'h101] = 8'h00;
    exp_q.push_back(nop_at(64'h100));
    exp_q.push_back(hlt_at(64'h101));
    lat = 6;
    d_ready = 1'b0;
    do_reset();
    a0 = acc_count;
    for (int n = 0; n < 50 && acc_count == a0; n++) step(1);
    check("stale_req_seen", 64'(acc_count > a0), 64'd1);
    redirect_pulse(4'd7, 1'b0, 64'h100, 4'd0, 64'd0);
    d_ready = 1'b1;
    wait_empty(300, "stale_done");
    lat = 0;

    // address error under a straddling irmovq, then an illegal opcode byte
    img.delete();
    for (int i = 0; i < 6; i++) img[64'(i)] = 8'h10;
    img[6] = 8'h30; img[7] = 8'hF2; img[8] = 8'h0A; img[64'h40] = 8'hF0;
    err_lo = 64'h08; err_hi = 64'h40;
    for (int i = 0; i < 6; i++) exp_q.push_back(nop_at(64'(i)));
    exp_q.push_back(mk(3'd2, 4'd1, 4'd0, 4'hF, 4'hF, 64'd0, 64'd6, 64'd6, 64'd6));
    d_ready = 1'b1;
    do_reset();
    wait_empty(300, "adr_done");
    step(3);
    check("adr_halted", 64'(f_valid), 64'd0);
    exp_q.push_back(mk(3'd3, 4'hF, 4'd0, 4'hF, 4'hF, 64'd0, 64'h41, 64'h41, 64'h40));
    redirect_pulse(4'd0, 1'b1, 64'd0, 4'd9, 64'h40);
    wait_empty(300, "ins_done");
    step(3);
    check("ins_halted", 64'(f_valid), 64'd0);

    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/y86_prefetch_fetch.md
Y86_PREFETCH_FETCH -- requirements
Module: y86_prefetch_fetch

Interface
REQ-001 SHALL have parameter FETCH_BYTES, default 8, meaning bytes returned per instruction-memory response (legal values 4, 8 or 16).
REQ-002 SHALL have parameter QDEPTH, default 32, meaning instruction byte queue capacity (power of 2, at least FETCH_BYTES+10).
REQ-003 SHALL have parameter RESET_PC, default 64'h0, meaning fetch address after reset.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 imem_req_valid / imem_req_ready  out / in  1 / 1  memory request handshake.
REQ-007 imem_req_addr  out  64  byte address of request.
REQ-008 imem_rsp_valid  in  1  response strobe (no backpressure).
REQ-009 imem_rsp_data  in  8*FETCH_BYTES  response bytes, byte 0 in bits [7:0].
REQ-010 imem_rsp_error  in  1  address error for that response.
REQ-011 M_icode, M_Cnd, M_valA  in  4, 1, 64  memory-stage branch-resolution inputs.
REQ-012 W_icode, W_valM  in  4, 64  writeback-stage return-address inputs.
REQ-013 f_valid / d_ready  out / in  1 / 1  instruction handoff to decode; transfer when both high.
REQ-014 f_stat, f_icode, f_ifun, f_rA, f_rB  out  3, 4, 4, 4, 4  decoded fields (stat 1=AOK, 2=ADR, 3=INS, 4=HLT).
REQ-015 f_valC, f_valP, f_predPC, f_pc  out  64 each  constant, next sequential PC, predicted PC, instruction PC.

Function
REQ-016 Queue SHALL hold bytes in order with head PC register; occupancy 0..QDEPTH; pointers wrap modulo QDEPTH.
REQ-017 Request SHALL issue only when no request outstanding, state RUN, no error latched, and free space (QDEPTH - occupancy) >= FETCH_BYTES; at most one request outstanding.
REQ-018 Request address SHALL be the fetch-address register; it advances by FETCH_BYTES on each accepted request (imem_req_valid & imem_req_ready); imem_req_valid SHALL stay high with stable address until accepted.
REQ-019 Response SHALL push FETCH_BYTES bytes at the next rising edge; push and pop in the same cycle SHALL both take effect.
REQ-020 Head byte decode: icode=[7:4], ifun=[3:0]; need_regids for icodes 2,3,4,5,6,10,11; need_valC for 3,4,5,7,8; length = 1 + need_regids + 8*need_valC.
REQ-021 rA/rB SHALL be byte 1 nibbles when need_regids, else 4'hF; valC SHALL be little-endian 8 bytes at offset 1+need_regids when need_valC, else 0.
REQ-022 f_valid SHALL assert in RUN when occupancy >= length; pop of length bytes and head PC += length on transfer.
REQ-023 f_valP = f_pc + length; f_predPC = f_valC for icode 7 or 8, else f_valP.
REQ-024 f_stat SHALL be HLT for icode 0, INS for icode > 11, AOK otherwise; INS instruction length SHALL be 1.
REQ-025 On transfer of a HLT or INS instruction, state SHALL go RUN->HALTED; HALTED emits nothing and issues no requests.
REQ-026 imem_rsp_error SHALL latch error flag and push no bytes; when flag set and occupancy < length (including 0), SHALL present f_valid with f_stat=ADR, f_icode=1, f_pc=head PC, then go HALTED on transfer.
REQ-027 Redirect: (M_icode==7 & M_Cnd==0) selects M_valA; else W_icode==9 selects W_valM; M takes priority.
REQ-028 On redirect: queue flushed, head PC and fetch address := redirect target, error flag cleared, state := RUN, f_valid low that cycle, response of any in-flight request discarded (epoch toggle).
REQ-029 f_valid and all outputs SHALL be held stable while f_valid & !d_ready, except on redirect.

Reset
REQ-030 rst_n low SHALL immediately: occupancy 0, head PC and fetch address := RESET_PC, state RUN, error flag 0, outstanding 0, f_valid 0, imem_req_valid 0, f_stat 1, fields 0 except f_rA/f_rB 4'hF.
REQ-031 A response arriving for a request issued before reset SHALL be discarded.

Verification
REQ-032 Reset, memory returns 30 F4 0A 00.. (irmovq $10,%rsp) then 00 -> f_icode 3, f_rB 4, f_valC 10, f_valP 10, then f_stat HLT at pc 10, then no further requests.
REQ-033 jXX at pc 0 with target 0x40 -> f_predPC 0x40; later M_icode 7, M_Cnd 0, M_valA 0x09 -> queue flushed, next f_pc 0x09.
REQ-034 Same cycle M mispredict (M_valA 0x20) and W ret (W_valM 0x80) -> next f_pc 0x20.
REQ-035 d_ready low 5 cycles, FETCH_BYTES 8, QDEPTH 32 -> requests stop at occupancy > 24; outputs stable; no byte lost after release.
REQ-036 Redirect while request outstanding -> stale response dropped, first instruction from new target.
REQ-037 imem_rsp_error on second response with 10-byte irmovq straddling -> f_stat ADR at that pc; byte 0xF0 -> f_stat INS, length 1.
